// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration stream loader: widths, the FSM
// state encoding and a helper that computes the last bit index of a burst.
package cfg_loader_pkg;

   localparam int CFG_LEN_W  = 16;
   localparam int CFG_BYTE_W = 8;

   // State encoding kept as plain constants so older code can reuse it.
   typedef logic [2:0] state_t;
   localparam state_t HUNT  = 3'd0;
   localparam state_t LEN_H = 3'd1;
   localparam state_t LEN_L = 3'd2;
   localparam state_t FETCH = 3'd3;
   localparam state_t SHIFT = 3'd4;
   localparam state_t CHECK = 3'd5;
   localparam state_t ERR   = 3'd6;

   // Index of the last bit to shift from the current byte: min(8, rem) - 1.
   // Only called with rem > 0.
   function automatic logic [2:0] last_bit_idx(input logic [CFG_LEN_W-1:0] rem);
      if (rem >= CFG_LEN_W'(8))
         return 3'd7;
      else
         return rem[2:0] - 3'd1;
   endfunction

endpackage

// File: rtl/cfg_piso.sv
// 8-bit parallel-in / serial-out register. The serial output is always the
// current LSB; each shift moves the next bit down into position 0.
module cfg_piso
   import cfg_loader_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  load,
   input  logic                  shift,
   input  logic [CFG_BYTE_W-1:0] pdata,
   output logic                  sdata
);

   logic [CFG_BYTE_W-1:0] sr_reg;

   // Load has priority; a shift fills the top with zero.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)
         sr_reg <= '0;
      else if (load)
         sr_reg <= pdata;
      else if (shift)
         sr_reg <= {1'b0, sr_reg[CFG_BYTE_W-1:1]};
   end

   assign sdata = sr_reg[0];

endmodule

// File: rtl/cfg_stream_loader.sv
// Configuration stream loader: parses SYNC / LEN_HI / LEN_LO / payload / CHK
// frames, shifts the payload LSB-first onto the configuration chain and
// strobes CFG_LATCH only when the length and XOR checksum are both good.
module cfg_stream_loader
   import cfg_loader_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = 8'hA5,
   parameter int         MAX_BITS  = 4096
)(
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [7:0] DIN,
   input  logic       DIN_VALID,
   output logic       DIN_READY,
   output logic       CFG_DATA,
   output logic       CFG_SHIFT,
   output logic       CFG_LATCH,
   output logic       DONE,
   output logic       ERROR
);

   localparam logic [CFG_LEN_W-1:0] MAX_LEN = CFG_LEN_W'(MAX_BITS);

   state_t                state_reg;
   logic [CFG_BYTE_W-1:0] len_hi_reg;
   logic [CFG_LEN_W-1:0]  bits_rem_reg;
   logic [2:0]            bit_cnt_reg;
   logic [2:0]            last_idx_reg;
   logic [CFG_BYTE_W-1:0] chk_reg;
   logic                  run_reg;
   logic                  latch_reg;
   logic                  done_reg;
   logic                  error_reg;

   logic                  accept;
   logic                  accepting_state;
   logic [CFG_LEN_W-1:0]  len_full;
   logic                  len_bad;
   logic                  piso_load;
   logic                  piso_shift;
   logic                  piso_bit;

   // run_reg holds DIN_READY low until the first edge after reset release.
   assign accepting_state = (state_reg == HUNT)  || (state_reg == LEN_H) ||
                            (state_reg == LEN_L) || (state_reg == FETCH) ||
                            (state_reg == CHECK);
   assign DIN_READY  = run_reg && accepting_state;
   assign accept     = DIN_VALID && DIN_READY;

   assign len_full   = {len_hi_reg, DIN};
   assign len_bad    = (len_full == '0) || (len_full > MAX_LEN);

   assign piso_load  = accept && (state_reg == FETCH);
   assign piso_shift = (state_reg == SHIFT);

   cfg_piso u_piso (
      .CLK   (CLK),
      .RST_N (RST_N),
      .load  (piso_load),
      .shift (piso_shift),
      .pdata (DIN),
      .sdata (piso_bit)
   );

   // Frame FSM with its length/bit counters, checksum and sticky status flags.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg    <= HUNT;
         len_hi_reg   <= '0;
         bits_rem_reg <= '0;
         bit_cnt_reg  <= '0;
         last_idx_reg <= '0;
         chk_reg      <= '0;
         run_reg      <= 1'b0;
         latch_reg    <= 1'b0;
         done_reg     <= 1'b0;
         error_reg    <= 1'b0;
      end else begin
         run_reg   <= 1'b1;
         latch_reg <= 1'b0;
         case (state_reg)
            HUNT: begin
               if (accept && (DIN == SYNC_BYTE)) begin
                  done_reg  <= 1'b0;
                  error_reg <= 1'b0;
                  state_reg <= LEN_H;
               end
            end
            LEN_H: begin
               if (accept) begin
                  len_hi_reg <= DIN;
                  state_reg  <= LEN_L;
               end
            end
            LEN_L: begin
               if (accept) begin
                  if (len_bad) begin
                     error_reg <= 1'b1;
                     state_reg <= ERR;
                  end else begin
                     bits_rem_reg <= len_full;
                     chk_reg      <= '0;
                     state_reg    <= FETCH;
                  end
               end
            end
            FETCH: begin
               if (accept) begin
                  chk_reg      <= chk_reg ^ DIN;
                  bit_cnt_reg  <= '0;
                  last_idx_reg <= last_bit_idx(bits_rem_reg);
                  state_reg    <= SHIFT;
               end
            end
            SHIFT: begin
               if (bits_rem_reg != '0)
                  bits_rem_reg <= bits_rem_reg - CFG_LEN_W'(1);
               bit_cnt_reg <= bit_cnt_reg + 3'd1;
               if (bit_cnt_reg == last_idx_reg)
                  state_reg <= (bits_rem_reg == CFG_LEN_W'(1)) ? CHECK : FETCH;
            end
            CHECK: begin
               if (accept) begin
                  if (DIN == chk_reg) begin
                     latch_reg <= 1'b1;
                     done_reg  <= 1'b1;
                     state_reg <= HUNT;
                  end else begin
                     error_reg <= 1'b1;
                     state_reg <= ERR;
                  end
               end
            end
            ERR: begin
               state_reg <= HUNT;
            end
            default: begin
               state_reg <= HUNT;
            end
         endcase
      end
   end

   assign CFG_SHIFT = (state_reg == SHIFT);
   assign CFG_DATA  = CFG_SHIFT && piso_bit;
   assign CFG_LATCH = latch_reg;
   assign DONE      = done_reg;
   assign ERROR     = error_reg;

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Directed bench for cfg_stream_loader: a scoreboard queue holds the expected
// chain bits of each frame and a negedge monitor pops one per CFG_SHIFT cycle.
module tb_cfg_stream_loader;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic [7:0] DIN = 8'h00;
   logic       DIN_VALID = 1'b0;
   logic       DIN_READY;
   logic       CFG_DATA;
   logic       CFG_SHIFT;
   logic       CFG_LATCH;
   logic       DONE;
   logic       ERROR;

   int         n_checks = 0;
   int         n_pass = 0;
   int         shift_cnt = 0;
   int         latch_cnt = 0;
   bit         exp_q[$];
   logic [7:0] pl [0:511];

   cfg_stream_loader #(.SYNC_BYTE(8'hA5), .MAX_BITS(4096)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .DIN       (DIN),
      .DIN_VALID (DIN_VALID),
      .DIN_READY (DIN_READY),
      .CFG_DATA  (CFG_DATA),
      .CFG_SHIFT (CFG_SHIFT),
      .CFG_LATCH (CFG_LATCH),
      .DONE      (DONE),
      .ERROR     (ERROR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Monitor: every shift cycle pops one expected bit; every latch is checked.
   always @(negedge CLK) begin
      if (RST_N) begin
         if (CFG_SHIFT) begin
            bit e;
            shift_cnt++;
            check("ready_low_in_shift", 32'(DIN_READY), 32'd0);
            check("shift_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("cfg_data", 32'(CFG_DATA), 32'(e));
            end
         end
         if (CFG_LATCH) begin
            latch_cnt++;
            check("done_with_latch", 32'(DONE), 32'd1);
            check("ready_with_latch", 32'(DIN_READY), 32'd1);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit stall);
      int guard = 0;
      DIN = b;
      forever begin
         @(negedge CLK);
         DIN_VALID = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (DIN_VALID && DIN_READY) begin
            @(posedge CLK);
            #1;
            DIN_VALID = 1'b0;
            $display("byte %02h accepted at %0t", b, $time);
            return;
         end
         guard++;
         if (guard > 200) begin
            check("accept_timeout", 32'(guard), 32'd0);
            DIN_VALID = 1'b0;
            return;
         end
      end
   endtask

   task automatic send_frame(input logic [15:0] len, input int nb, input bit bad_chk, input bit stall);
      logic [7:0] c = 8'h00;
      int rem = int'(len);
      int n;
      send_byte(8'hA5, stall);
      send_byte(len[15:8], stall);
      send_byte(len[7:0], stall);
      for (int i = 0; i < nb; i++) begin
         c = c ^ pl[i];
         n = (rem >= 8) ? 8 : rem;
         for (int k = 0; k < n; k++) exp_q.push_back(pl[i][k]);
         rem -= n;
         send_byte(pl[i], stall);
      end
      send_byte(bad_chk ? (c ^ 8'h01) : c, stall);
      repeat (3) @(negedge CLK);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      int l0;
      int g;

      // Reset state
      repeat (3) @(negedge CLK);
      check("rst_ready", 32'(DIN_READY), 32'd0);
      check("rst_shift", 32'(CFG_SHIFT), 32'd0);
      check("rst_latch", 32'(CFG_LATCH), 32'd0);
      check("rst_done", 32'(DONE), 32'd0);
      check("rst_error", 32'(ERROR), 32'd0);
      RST_N = 1'b1;
      #1;
      check("ready_before_first_edge", 32'(DIN_READY), 32'd0);
      @(negedge CLK);
      check("ready_after_first_edge", 32'(DIN_READY), 32'd1);

      // Good frame A5 00 0C 3C 05 39
      pl[0] = 8'h3C; pl[1] = 8'h05;
      s0 = shift_cnt; l0 = latch_cnt;
      send_frame(16'd12, 2, 1'b0, 1'b0);
      check("good_shifts", 32'(shift_cnt - s0), 32'd12);
      check("good_latch", 32'(latch_cnt - l0), 32'd1);
      check("good_done", 32'(DONE), 32'd1);
      check("good_error", 32'(ERROR), 32'd0);
      check("good_queue_empty", 32'(exp_q.size()), 32'd0);

      // Bad checksum (38)
      s0 = shift_cnt; l0 = latch_cnt;
      send_frame(16'd12, 2, 1'b1, 1'b0);
      check("badchk_shifts", 32'(shift_cnt - s0), 32'd12);
      check("badchk_latch", 32'(latch_cnt - l0), 32'd0);
      check("badchk_done", 32'(DONE), 32'd0);
      check("badchk_error", 32'(ERROR), 32'd1);

      // LEN = 0
      s0 = shift_cnt;
      send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b0);
      repeat (3) @(negedge CLK);
      check("len0_error", 32'(ERROR), 32'd1);
      check("len0_done", 32'(DONE), 32'd0);
      check("len0_shifts", 32'(shift_cnt - s0), 32'd0);

      // Garbage before sync, then a 20-bit good frame
      send_byte(8'h00, 1'b0); send_byte(8'hFF, 1'b0); send_byte(8'h5A, 1'b0);
      @(negedge CLK);
      check("garbage_error_kept", 32'(ERROR), 32'd1);
      check("garbage_ready", 32'(DIN_READY), 32'd1);
      for (int i = 0; i < 3; i++) pl[i] = 8'($urandom_range(0, 255));
      l0 = latch_cnt;
      send_frame(16'd20, 3, 1'b0, 1'b0);
      check("after_garbage_done", 32'(DONE), 32'd1);
      check("after_garbage_error", 32'(ERROR), 32'd0);
      check("after_garbage_latch", 32'(latch_cnt - l0), 32'd1);

      // LEN = 4097
      s0 = shift_cnt;
      send_byte(8'hA5, 1'b0); send_byte(8'h10, 1'b0); send_byte(8'h01, 1'b0);
      repeat (3) @(negedge CLK);
      check("len4097_error", 32'(ERROR), 32'd1);
      check("len4097_done", 32'(DONE), 32'd0);
      check("len4097_shifts", 32'(shift_cnt - s0), 32'd0);

      // 16-bit frame with random DIN_VALID stalls
      pl[0] = 8'($urandom_range(0, 255)); pl[1] = 8'($urandom_range(0, 255));
      s0 = shift_cnt; l0 = latch_cnt;
      send_frame(16'd16, 2, 1'b0, 1'b1);
      check("stall_shifts", 32'(shift_cnt - s0), 32'd16);
      check("stall_latch", 32'(latch_cnt - l0), 32'd1);
      check("stall_done", 32'(DONE), 32'd1);
      check("stall_queue_empty", 32'(exp_q.size()), 32'd0);

      // LEN = 4096 (largest legal)
      for (int i = 0; i < 512; i++) pl[i] = 8'($urandom_range(0, 255));
      s0 = shift_cnt; l0 = latch_cnt;
      send_frame(16'd4096, 512, 1'b0, 1'b0);
      check("max_shifts", 32'(shift_cnt - s0), 32'd4096);
      check("max_latch", 32'(latch_cnt - l0), 32'd1);
      check("max_done", 32'(DONE), 32'd1);
      check("max_error", 32'(ERROR), 32'd0);

      // Reset in the middle of a SHIFT burst
      pl[0] = 8'hFF;
      for (int k = 0; k < 8; k++) exp_q.push_back(pl[0][k]);
      send_byte(8'hA5, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h10, 1'b0);
      send_byte(pl[0], 1'b0);
      g = 0;
      while (!CFG_SHIFT && g < 50) begin
         @(negedge CLK);
         g++;
      end
      check("midreset_shift_started", 32'(CFG_SHIFT), 32'd1);
      repeat (2) @(negedge CLK);
      #2;
      RST_N = 1'b0;
      #1;
      check("midreset_shift", 32'(CFG_SHIFT), 32'd0);
      check("midreset_data", 32'(CFG_DATA), 32'd0);
      check("midreset_ready", 32'(DIN_READY), 32'd0);
      check("midreset_latch", 32'(CFG_LATCH), 32'd0);
      check("midreset_done", 32'(DONE), 32'd0);
      check("midreset_error", 32'(ERROR), 32'd0);
      exp_q.delete();
      l0 = latch_cnt; s0 = shift_cnt;
      repeat (2) @(negedge CLK);
      #1;
      RST_N = 1'b1;
      @(negedge CLK);
      check("postreset_ready", 32'(DIN_READY), 32'd1);
      repeat (20) @(negedge CLK);
      check("postreset_no_latch", 32'(latch_cnt - l0), 32'd0);
      check("postreset_no_shift", 32'(shift_cnt - s0), 32'd0);

      // Recovery frame
      pl[0] = 8'h3C; pl[1] = 8'h05;
      l0 = latch_cnt;
      send_frame(16'd12, 2, 1'b0, 1'b0);
      check("recover_latch", 32'(latch_cnt - l0), 32'd1);
      check("recover_done", 32'(DONE), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
